// File: rtl/move_collector.sv
// rtl/move_collector.sv - round-robin drain of the column move FIFOs onto one tagged move stream
module move_collector #(
   parameter int NCOL = 8,
   parameter int MW   = 160,
   parameter int CW   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [NCOL*MW-1:0] col_fifo_out,
   input  logic [NCOL-1:0]   col_fifo_empty,
   input  logic [NCOL-1:0]   col_done,
   output logic [NCOL-1:0]   col_rden,
   output logic [MW-1:0]     move_out,
   output logic [2:0]        move_col,
   output logic              move_valid,
   input  logic              move_ready,
   output logic [CW-1:0]     move_count,
   output logic              all_done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SCAN  = 3'd1,
      S_READ  = 3'd2,
      S_LATCH = 3'd3,
      S_OUT   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        ptr_q, ptr_d;
   logic [2:0]        sel_q, sel_d;
   logic [NCOL-1:0]   col_rden_q, col_rden_d;
   logic [MW-1:0]     move_out_q, move_out_d;
   logic [2:0]        move_col_q, move_col_d;
   logic              move_valid_q, move_valid_d;
   logic [CW-1:0]     move_count_q, move_count_d;
   logic              all_done_q, all_done_d;

   logic              scan_found;
   logic [2:0]        scan_sel;
   logic [2:0]        scan_idx;

   // Priority search for the first non-empty column starting at ptr; walking the
   // offsets downward lets the smallest offset overwrite any later candidate.
   always_comb begin
      scan_found = 1'b0;
      scan_sel   = 3'd0;
      scan_idx   = 3'd0;
      for (int i = NCOL - 1; i >= 0; i--) begin
         scan_idx = ptr_q + 3'(i);
         if (!col_fifo_empty[scan_idx]) begin
            scan_found = 1'b1;
            scan_sel   = scan_idx;
         end
      end
   end

   // State and datapath registers, cleared asynchronously so an in-flight word is dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         ptr_q        <= 3'd0;
         sel_q        <= 3'd0;
         col_rden_q   <= '0;
         move_out_q   <= '0;
         move_col_q   <= 3'd0;
         move_valid_q <= 1'b0;
         move_count_q <= '0;
         all_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         sel_q        <= sel_d;
         col_rden_q   <= col_rden_d;
         move_out_q   <= move_out_d;
         move_col_q   <= move_col_d;
         move_valid_q <= move_valid_d;
         move_count_q <= move_count_d;
         all_done_q   <= all_done_d;
      end
   end

   // Next-state: one read per SCAN/READ/LATCH/OUT lap; completion only judged in SCAN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SCAN;
         S_SCAN: begin
            if (scan_found)     state_d = S_READ;
            else if (&col_done) state_d = S_DONE;
         end
         S_READ:  state_d = S_LATCH;
         S_LATCH: state_d = S_OUT;
         S_OUT:   if (move_ready) state_d = S_SCAN;
         S_DONE:  if (start) state_d = S_SCAN;
         default: state_d = S_IDLE;
      endcase
   end

   // Output/datapath next values; everything holds unless the current state updates it.
   always_comb begin
      ptr_d        = ptr_q;
      sel_d        = sel_q;
      col_rden_d   = '0;
      move_out_d   = move_out_q;
      move_col_d   = move_col_q;
      move_valid_d = move_valid_q;
      move_count_d = move_count_q;
      all_done_d   = all_done_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               ptr_d        = 3'd0;
               move_count_d = '0;
               all_done_d   = 1'b0;
            end
         end
         S_SCAN: begin
            if (scan_found) begin
               sel_d      = scan_sel;
               col_rden_d = NCOL'(1) << scan_sel;
            end else if (&col_done) begin
               all_done_d = 1'b1;
            end
         end
         S_LATCH: begin
            move_out_d   = col_fifo_out[MW*sel_q +: MW];
            move_col_d   = sel_q;
            move_valid_d = 1'b1;
         end
         S_OUT: begin
            if (move_ready) begin
               move_valid_d = 1'b0;
               ptr_d        = sel_q + 3'd1;
               if (!(&move_count_q)) move_count_d = move_count_q + CW'(1);
            end
         end
         default: ;
      endcase
   end

   assign col_rden   = col_rden_q;
   assign move_out   = move_out_q;
   assign move_col   = move_col_q;
   assign move_valid = move_valid_q;
   assign move_count = move_count_q;
   assign all_done   = all_done_q;

endmodule

// File: tb/tb_move_collector.sv
// tb/tb_move_collector.sv - randomized self-checking bench for move_collector with column FIFO fixture
module tb_move_collector;
   localparam int NCOL = 8;
   localparam int MW   = 160;
   localparam int CW   = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [NCOL*MW-1:0] col_fifo_out;
   logic [NCOL-1:0]   col_fifo_empty;
   logic [NCOL-1:0]   col_done = '0;
   logic [NCOL-1:0]   col_rden;
   logic [MW-1:0]     move_out;
   logic [2:0]        move_col;
   logic              move_valid;
   logic              move_ready = 1'b0;
   logic [CW-1:0]     move_count;
   logic              all_done;

   move_collector #(.NCOL(NCOL), .MW(MW), .CW(CW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .col_fifo_out(col_fifo_out), .col_fifo_empty(col_fifo_empty), .col_done(col_done),
      .col_rden(col_rden), .move_out(move_out), .move_col(move_col),
      .move_valid(move_valid), .move_ready(move_ready),
      .move_count(move_count), .all_done(all_done)
   );

   always #5 clk = ~clk;

   // column FIFO fixture: tail written by stimulus, head advanced by read enables
   logic [MW-1:0] mem [NCOL][16];
   logic [MW-1:0] fdata [NCOL];
   int head [NCOL] = '{default: 0};
   int tail [NCOL] = '{default: 0};
   int rden_cnt [NCOL] = '{default: 0};
   int bad_rden = 0;
   int cyc = 0;

   // accepted-move log
   logic [2:0]    got_col  [512];
   logic [MW-1:0] got_word [512];
   int            got_cyc  [512];
   int            got_n = 0;

   int pass_cnt = 0;
   int total_cnt = 0;

   always_comb begin
      for (int c = 0; c < NCOL; c++) begin
         col_fifo_empty[c] = (head[c] == tail[c]);
         col_fifo_out[c*MW +: MW] = fdata[c];
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int c = 0; c < NCOL; c++) begin
         if (col_rden[c]) begin
            rden_cnt[c] <= rden_cnt[c] + 1;
            if (head[c] == tail[c]) bad_rden <= bad_rden + 1;
            else begin
               fdata[c] <= mem[c][head[c] % 16];
               head[c]  <= head[c] + 1;
            end
         end
      end
      if (reset && move_valid && move_ready) begin
         got_col[got_n]  <= move_col;
         got_word[got_n] <= move_out;
         got_cyc[got_n]  <= cyc;
         got_n           <= got_n + 1;
      end
   end

   task automatic push(input int c, input logic [MW-1:0] w);
      mem[c][tail[c] % 16] = w;
      tail[c] = tail[c] + 1;
   endtask

   task automatic flush();
      for (int c = 0; c < NCOL; c++) tail[c] = head[c];
   endtask

   function automatic logic [MW-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic run_until(input int target, input bit need_done, input bit rnd, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (rnd) move_ready = 1'($urandom_range(0, 1));
         if (got_n >= target && (!need_done || all_done)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit seen;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt += 6;
      if (col_rden !== '0) $display("FAIL reset_rden got %h want 0", col_rden); else pass_cnt++;
      if (move_out !== '0) $display("FAIL reset_move_out got %h want 0", move_out); else pass_cnt++;
      if (move_col !== 3'd0) $display("FAIL reset_move_col got %0d want 0", move_col); else pass_cnt++;
      if (move_valid !== 1'b0) $display("FAIL reset_move_valid got %b want 0", move_valid); else pass_cnt++;
      if (move_count !== '0) $display("FAIL reset_move_count got %0d want 0", move_count); else pass_cnt++;
      if (all_done !== 1'b0) $display("FAIL reset_all_done got %b want 0", all_done); else pass_cnt++;
      reset = 1'b1;
      col_done = 8'hFF;
      push(4, rand_word());
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (col_rden !== '0 || move_valid !== 1'b0 || all_done !== 1'b0) seen = 1'b1;
      end
      total_cnt++;
      if (seen) $display("FAIL idle_quiet got activity want none"); else pass_cnt++;
      flush();
   endtask

   task automatic test_single();
      logic [MW-1:0] a, b;
      int base, r3, rsum;
      bit ok;
      a = rand_word(); b = rand_word();
      push(3, a); push(3, b);
      col_done = 8'hFF; move_ready = 1'b1;
      base = got_n; r3 = rden_cnt[3];
      rsum = 0; for (int c = 0; c < NCOL; c++) rsum += rden_cnt[c];
      pulse_start();
      run_until(base + 2, 1'b1, 1'b0, ok);
      total_cnt++;
      if (!ok) $display("FAIL single_timeout got %0d moves want 2", got_n - base); else pass_cnt++;
      total_cnt += 7;
      if (got_col[base] !== 3'd3 || got_word[base] !== a)
         $display("FAIL single_first got col %0d word %h want col 3 word %h", got_col[base], got_word[base], a);
      else pass_cnt++;
      if (got_col[base+1] !== 3'd3 || got_word[base+1] !== b)
         $display("FAIL single_second got col %0d word %h want col 3 word %h", got_col[base+1], got_word[base+1], b);
      else pass_cnt++;
      if (got_cyc[base+1] - got_cyc[base] !== 4)
         $display("FAIL single_period got %0d want 4", got_cyc[base+1] - got_cyc[base]); else pass_cnt++;
      if (move_count !== 16'd2) $display("FAIL single_count got %0d want 2", move_count); else pass_cnt++;
      if (all_done !== 1'b1) $display("FAIL single_all_done got %b want 1", all_done); else pass_cnt++;
      if (rden_cnt[3] - r3 !== 2) $display("FAIL single_rden3 got %0d want 2", rden_cnt[3] - r3); else pass_cnt++;
      for (int c = 0; c < NCOL; c++) rsum -= rden_cnt[c];
      if (-rsum !== 2) $display("FAIL single_other_rden got %0d total reads want 2", -rsum); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      logic [MW-1:0] w [4];
      logic [2:0] ec [4];
      int base;
      bit ok;
      for (int i = 0; i < 4; i++) w[i] = rand_word();
      push(1, w[0]); push(1, w[1]); push(6, w[2]); push(6, w[3]);
      ec[0] = 3'd1; ec[1] = 3'd6; ec[2] = 3'd1; ec[3] = 3'd6;
      base = got_n; move_ready = 1'b1;
      pulse_start();
      run_until(base + 4, 1'b1, 1'b0, ok);
      total_cnt++;
      if (!ok) $display("FAIL rr_timeout got %0d moves want 4", got_n - base); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         int wi;
         wi = (i == 0) ? 0 : (i == 1) ? 2 : (i == 2) ? 1 : 3;
         total_cnt++;
         if (got_col[base+i] !== ec[i] || got_word[base+i] !== w[wi])
            $display("FAIL rr_move%0d got col %0d want col %0d", i, got_col[base+i], ec[i]);
         else pass_cnt++;
      end
      total_cnt++;
      if (move_count !== 16'd4) $display("FAIL rr_count got %0d want 4", move_count); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      logic [MW-1:0] w, held_w;
      logic [2:0] held_c;
      int base;
      bit ok, unstable;
      w = rand_word();
      push(2, w);
      move_ready = 1'b0; base = got_n;
      pulse_start();
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (move_valid) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      total_cnt++;
      if (!ok) $display("FAIL bp_valid_timeout got 0 want 1"); else pass_cnt++;
      held_w = move_out; held_c = move_col; unstable = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (move_out !== held_w || move_col !== held_c || move_valid !== 1'b1 || col_rden !== '0)
            unstable = 1'b1;
      end
      total_cnt += 2;
      if (unstable) $display("FAIL bp_hold got change want stable"); else pass_cnt++;
      if (held_w !== w || held_c !== 3'd2) $display("FAIL bp_word got col %0d want col 2", held_c); else pass_cnt++;
      move_ready = 1'b1;
      run_until(base + 1, 1'b1, 1'b0, ok);
      total_cnt += 2;
      if (!ok || got_word[base] !== w) $display("FAIL bp_accept got %0d moves want 1", got_n - base); else pass_cnt++;
      if (move_count !== 16'd1) $display("FAIL bp_count got %0d want 1", move_count); else pass_cnt++;
   endtask

   task automatic test_late_done();
      logic [MW-1:0] w;
      int base;
      bit ok, act;
      col_done = 8'h7F; move_ready = 1'b1; base = got_n;
      pulse_start();
      act = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (all_done !== 1'b0 || move_valid !== 1'b0 || col_rden !== '0) act = 1'b1;
      end
      total_cnt++;
      if (act) $display("FAIL late_wait got activity want none"); else pass_cnt++;
      w = rand_word();
      push(7, w);
      col_done = 8'hFF;
      run_until(base + 1, 1'b1, 1'b0, ok);
      total_cnt += 3;
      if (!ok) $display("FAIL late_timeout got %0d moves want 1", got_n - base); else pass_cnt++;
      if (got_col[base] !== 3'd7 || got_word[base] !== w)
         $display("FAIL late_move got col %0d want col 7", got_col[base]); else pass_cnt++;
      if (move_count !== 16'd1 || all_done !== 1'b1)
         $display("FAIL late_final got count %0d done %b want 1 1", move_count, all_done); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [MW-1:0] w;
      int base;
      bit ok;
      push(0, rand_word()); push(0, rand_word());
      move_ready = 1'b1;
      pulse_start();
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (col_rden !== '0) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      total_cnt += 2;
      if (!ok) $display("FAIL mid_rden_timeout got 0 want rden"); else pass_cnt++;
      if (move_out !== '0 || move_col !== 3'd0 || move_valid !== 1'b0 || col_rden !== '0 ||
          move_count !== '0 || all_done !== 1'b0)
         $display("FAIL mid_reset_outputs got out %h col %0d want 0", move_out, move_col);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      flush();
      reset = 1'b1;
      w = rand_word();
      push(5, w);
      base = got_n;
      pulse_start();
      run_until(base + 1, 1'b1, 1'b0, ok);
      total_cnt++;
      if (!ok || move_count !== 16'd1 || got_word[base] !== w)
         $display("FAIL mid_restart got count %0d want 1", move_count);
      else pass_cnt++;
   endtask

   task automatic test_random();
      for (int pass = 0; pass < 5; pass++) begin
         logic [MW-1:0] wl [NCOL][4];
         int cnt [NCOL];
         int taken [NCOL];
         logic [2:0] ec [32];
         logic [MW-1:0] ew [32];
         int total, ptr, base, nbad;
         bit ok;
         total = 0;
         for (int c = 0; c < NCOL; c++) begin
            cnt[c] = $urandom_range(0, 3);
            taken[c] = 0;
            for (int j = 0; j < cnt[c]; j++) begin
               wl[c][j] = rand_word();
               push(c, wl[c][j]);
            end
            total += cnt[c];
         end
         // expected order: visit columns cyclically from the pointer, skip empty ones
         ptr = 0;
         for (int k = 0; k < total; k++) begin
            for (int off = 0; off < NCOL; off++) begin
               int c;
               c = (ptr + off) % NCOL;
               if (taken[c] < cnt[c]) begin
                  ec[k] = 3'(c);
                  ew[k] = wl[c][taken[c]];
                  taken[c]++;
                  ptr = (c + 1) % NCOL;
                  break;
               end
            end
         end
         base = got_n;
         pulse_start();
         run_until(base + total, 1'b1, 1'b1, ok);
         total_cnt++;
         if (!ok) $display("FAIL rand%0d_timeout got %0d moves want %0d", pass, got_n - base, total); else pass_cnt++;
         nbad = 0;
         for (int k = 0; k < total; k++) begin
            total_cnt++;
            if (got_col[base+k] !== ec[k] || got_word[base+k] !== ew[k]) begin
               if (nbad < 4) $display("FAIL rand%0d_move%0d got col %0d want col %0d", pass, k, got_col[base+k], ec[k]);
               nbad++;
            end else pass_cnt++;
         end
         total_cnt += 2;
         if (got_n - base !== total) $display("FAIL rand%0d_nmoves got %0d want %0d", pass, got_n - base, total); else pass_cnt++;
         if (move_count !== CW'(total) || all_done !== 1'b1)
            $display("FAIL rand%0d_final got count %0d done %b want %0d 1", pass, move_count, all_done, total);
         else pass_cnt++;
      end
      move_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_late_done();
      test_reset_mid();
      test_random();
      total_cnt++;
      if (bad_rden !== 0) $display("FAIL rden_on_empty got %0d want 0", bad_rden); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/move_collector.md
# move_collector

Downstream drain stage for the eight per-column move generators. It round-robins over the column move FIFOs, reading one 160-bit move word at a time. Each word is presented on a valid/ready stream tagged with its source column, and the block counts the moves delivered. When every column has reported done and every FIFO is empty, it raises a list-complete flag, which is the hand-off to move ordering/evaluation.

## Interface
- NCOL, 8, number of column units drained (column index width fixed at 3 bits)
- MW, 160, move word width (matches column FIFO output)
- CW, 16, move counter width
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low forces all state/outputs to reset values
- start  in  1  one-cycle pulse; begins a collection pass (honoured only in IDLE or DONE)
- col_fifo_out  in  NCOL*MW  column c data at [MW*c+MW-1 : MW*c]; valid the cycle after its rden
- col_fifo_empty  in  NCOL  column FIFO empty flags
- col_done  in  NCOL  column generation-finished flags (level)
- col_rden  out  NCOL  one-hot FIFO read enables, registered
- move_out  out  MW  captured move word
- move_col  out  3  source column of move_out
- move_valid  out  1  move_out/move_col valid
- move_ready  in  1  consumer accepts when high with move_valid
- move_count  out  CW  moves accepted this pass, saturating
- all_done  out  1  pass complete

## Operation
- States: IDLE, SCAN, READ, LATCH, OUT, DONE.
- IDLE: outputs quiet. start -> SCAN; move_count cleared to 0, round-robin pointer ptr cleared to 0.
- SCAN: choose sel = first column with col_fifo_empty low, searching ptr, ptr+1, … wrapping mod 8.
  - If one is found -> READ, with col_rden[sel] asserted.
  - Else, if col_done==8'hFF (all FIFOs empty) -> DONE.
  - Else stay in SCAN.
- READ: col_rden one-hot at sel for exactly this cycle -> LATCH.
- LATCH: col_rden=0; at the end of the cycle, move_out <= slice sel of col_fifo_out, move_col <= sel, move_valid <= 1 -> OUT.
- OUT: hold move_out/move_col/move_valid stable until move_ready=1. On the handshake edge:
  - move_valid <= 0;
  - move_count <= move_count+1, saturating at all ones;
  - ptr <= sel+1 (mod 8, 7 wraps to 0);
  - -> SCAN.
- DONE: all_done=1, held. start -> SCAN with count/ptr cleared and all_done <= 0. Otherwise stay in DONE.
- start in SCAN/READ/LATCH/OUT is ignored.
- col_rden is never asserted for a column whose empty flag was high in the deciding SCAN cycle.
- Completion is evaluated only in SCAN, so a move held in OUT always precedes all_done.

## Timing
- Reset values: col_rden=0, move_out=0, move_col=0, move_valid=0, move_count=0, all_done=0, state IDLE, ptr=0.
- reset low mid-operation: immediate return to reset values. An in-flight FIFO word is dropped; the column FIFOs are expected to be reset together.
- start at edge T: SCAN in T+1.
- Non-empty seen in SCAN cycle S: rden high in S+1, data sampled at the end of S+2, move_valid high from S+3.
- With move_ready held high, the handshake completes at the end of S+3, giving a 4-cycle period per move (SCAN, READ, LATCH, OUT).
- move_ready low: OUT is held indefinitely with no further reads.
- Column FIFO empty flags must reflect the prior read within 2 cycles; the minimum 3-cycle gap between reads of any column satisfies this.
- all_done asserts one cycle after the SCAN cycle that sees all empty and all done.
- move_count saturates: at all ones a further handshake leaves it unchanged.

## Test plan
- Reset/idle: reset low, then high with no start -> all outputs 0, col_rden never asserted over 20 cycles.
- Single column: start; FIFO 3 holds words A,B; col_done=8'hFF; move_ready=1.
  - Required: A then B on move_out with move_col=3, 4 cycles apart.
  - Then move_count=2 and all_done=1, and no rden on any other column.
- Round-robin: columns 1 and 6 each hold two words -> move_col sequence 1,6,1,6 with ptr wrap verified; move_count=4.
- Backpressure: move_ready low for 10 cycles while in OUT -> move_out/move_col stable, move_valid=1, col_rden=0 throughout; the move is accepted when ready rises.
- Late done: all FIFOs empty, col_done=8'h7F for 30 cycles -> stays in SCAN, all_done=0. Column 7 then pushes a word and sets done -> one move with move_col=7, then all_done=1.
- Reset mid-pass: reset low while in LATCH -> outputs zero within the same cycle. A new start after release gives move_count counting from 0.
